// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR initiator.
// Holds the request opcode encodings, CSR addresses, mstatus bit positions
// and the sequencer state type.
package csr_pkg;

    // Request opcodes. 3, 6 and 7 are unsupported and return resp_illegal.
    typedef enum logic [2:0] {
        OP_CSRRW = 3'd0,
        OP_CSRRS = 3'd1,
        OP_CSRRC = 3'd2,
        OP_ECALL = 3'd4,
        OP_MRET  = 3'd5
    } op_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

    typedef enum logic [3:0] {
        IDLE,
        ACC,
        T_STAT,
        T_EPC,
        T_CAUSE,
        T_VEC,
        R_STAT,
        R_EPC,
        RESP
    } state_t;

endpackage

// File: rtl/csr_alu.sv
// Combinational new-value function for CSRRW/CSRRS/CSRRC.
// Ports:
//   op       - request opcode
//   old      - current CSR value
//   src      - rs1 value or zero-extended zimm
//   src_zero - rs1 index / zimm is zero (set/clear become read-only)
//   wdata    - value to write
//   we       - write required
module csr_alu
    import csr_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] old,
    input  logic [XLEN-1:0] src,
    input  logic            src_zero,
    output logic [XLEN-1:0] wdata,
    output logic            we
);

    always_comb begin
        wdata = '0;
        we    = 1'b0;
        case (op)
            OP_CSRRW: begin
                wdata = src;
                we    = 1'b1;
            end
            OP_CSRRS: begin
                wdata = old | src;
                we    = !src_zero;
            end
            OP_CSRRC: begin
                wdata = old & ~src;
                we    = !src_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/csr_trap_seq.sv
// Initiator side of the machine-mode CSR port. Sequences CSR instructions,
// ECALL and MRET into at most one CSR write per cycle and returns rd data
// and/or a PC redirect through a one-cycle resp_valid pulse.
// Ports:
//   rst, WrClk              - synchronous active-high reset, clock
//   req_*                   - request from the core (latched on acceptance)
//   csr_rr / csr_busR       - CSR read address / combinational read data
//   csr_wr/csr_rw/csr_busW  - CSR write enable, address, data
//   resp_*                  - registered response, valid for one cycle
module csr_trap_seq
    import csr_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned ECALL_CAUSE = 11
) (
    input  logic            rst,
    input  logic            WrClk,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [11:0]     req_csr,
    input  logic [XLEN-1:0] req_src,
    input  logic            req_src_zero,
    input  logic            req_rd_zero,
    input  logic [XLEN-1:0] req_pc,
    output logic [11:0]     csr_rr,
    input  logic [XLEN-1:0] csr_busR,
    output logic            csr_wr,
    output logic [11:0]     csr_rw,
    output logic [XLEN-1:0] csr_busW,
    output logic            resp_valid,
    output logic            resp_rd_we,
    output logic [XLEN-1:0] resp_rd_data,
    output logic            resp_redirect,
    output logic [XLEN-1:0] resp_pc,
    output logic            resp_illegal
);

    state_t          state, state_n;
    logic [2:0]      lat_op;
    logic [11:0]     lat_csr;
    logic [XLEN-1:0] lat_src, lat_pc;
    logic            lat_src_zero, lat_rd_zero;
    logic [XLEN-1:0] alu_wdata, stat_trap, stat_ret;
    logic            alu_we, wr_c, accept;

    assign req_ready  = (state == IDLE) && !rst;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == RESP);
    // Reset kills any in-flight write, so a trap cannot half-complete.
    assign csr_wr     = wr_c && !rst;

    csr_alu #(.XLEN(XLEN)) u_alu (
        .op       (lat_op),
        .old      (csr_busR),
        .src      (lat_src),
        .src_zero (lat_src_zero),
        .wdata    (alu_wdata),
        .we       (alu_we)
    );

    always_comb begin
        stat_trap                                 = csr_busR;
        stat_trap[MSTATUS_MPIE]                   = csr_busR[MSTATUS_MIE];
        stat_trap[MSTATUS_MIE]                    = 1'b0;
        stat_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
        stat_ret                                  = csr_busR;
        stat_ret[MSTATUS_MIE]                     = csr_busR[MSTATUS_MPIE];
        stat_ret[MSTATUS_MPIE]                    = 1'b1;
        stat_ret[MSTATUS_MPP_HI:MSTATUS_MPP_LO]   = 2'b11;
    end

    // Read and write addresses are always driven together so the CSR file
    // may decode a write from either one.
    always_comb begin
        state_n  = state;
        csr_rr   = '0;
        csr_rw   = '0;
        csr_busW = '0;
        wr_c     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (req_op)
                        OP_CSRRW, OP_CSRRS, OP_CSRRC: state_n = ACC;
                        OP_ECALL:                     state_n = T_STAT;
                        OP_MRET:                      state_n = R_STAT;
                        default:                      state_n = RESP;
                    endcase
                end
            end
            ACC: begin
                csr_rr   = lat_csr;
                csr_rw   = lat_csr;
                csr_busW = alu_wdata;
                wr_c     = alu_we;
                state_n  = RESP;
            end
            T_STAT: begin
                csr_rr   = CSR_MSTATUS;
                csr_rw   = CSR_MSTATUS;
                csr_busW = stat_trap;
                wr_c     = 1'b1;
                state_n  = T_EPC;
            end
            T_EPC: begin
                csr_rr   = CSR_MEPC;
                csr_rw   = CSR_MEPC;
                csr_busW = lat_pc;
                wr_c     = 1'b1;
                state_n  = T_CAUSE;
            end
            T_CAUSE: begin
                csr_rr   = CSR_MCAUSE;
                csr_rw   = CSR_MCAUSE;
                csr_busW = XLEN'(ECALL_CAUSE);
                wr_c     = 1'b1;
                state_n  = T_VEC;
            end
            T_VEC: begin
                csr_rr   = CSR_MTVEC;
                csr_rw   = CSR_MTVEC;
                state_n  = RESP;
            end
            R_STAT: begin
                csr_rr   = CSR_MSTATUS;
                csr_rw   = CSR_MSTATUS;
                csr_busW = stat_ret;
                wr_c     = 1'b1;
                state_n  = R_EPC;
            end
            R_EPC: begin
                csr_rr   = CSR_MEPC;
                csr_rw   = CSR_MEPC;
                state_n  = RESP;
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge WrClk) begin
        if (accept) begin
            lat_op       <= req_op;
            lat_csr      <= req_csr;
            lat_src      <= req_src;
            lat_src_zero <= req_src_zero;
            lat_rd_zero  <= req_rd_zero;
            lat_pc       <= req_pc;
        end
    end

    // Response fields only change on the edge entering RESP.
    always_ff @(posedge WrClk) begin
        if (rst) begin
            state         <= IDLE;
            resp_rd_we    <= 1'b0;
            resp_rd_data  <= '0;
            resp_redirect <= 1'b0;
            resp_pc       <= '0;
            resp_illegal  <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (state_n == RESP) begin
                        resp_rd_we    <= 1'b0;
                        resp_rd_data  <= '0;
                        resp_redirect <= 1'b0;
                        resp_pc       <= '0;
                        resp_illegal  <= 1'b1;
                    end
                end
                ACC: begin
                    resp_rd_we    <= !lat_rd_zero;
                    resp_rd_data  <= csr_busR;
                    resp_redirect <= 1'b0;
                    resp_pc       <= '0;
                    resp_illegal  <= 1'b0;
                end
                T_VEC: begin
                    resp_rd_we    <= 1'b0;
                    resp_rd_data  <= '0;
                    resp_redirect <= 1'b1;
                    resp_pc       <= csr_busR & ~XLEN'(3);
                    resp_illegal  <= 1'b0;
                end
                R_EPC: begin
                    resp_rd_we    <= 1'b0;
                    resp_rd_data  <= '0;
                    resp_redirect <= 1'b1;
                    resp_pc       <= csr_busR;
                    resp_illegal  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/csr_trap_seq.md
Name: csr_trap_seq

Overview:
- Initiator side of the machine-mode CSR register-file port.
- Takes decoded CSR instructions (CSRRW/CSRRS/CSRRC; immediate forms are pre-muxed by decode), ECALL and MRET from the core.
- Sequences them into single-write-per-cycle accesses on the CSR read/write port.
- Returns rd writeback data and, for traps and returns, a PC redirect.

Parameters:
- XLEN, 32: data width of the CSR bus and PC.
- ECALL_CAUSE, 11: value written to mcause on ECALL (environment call from M-mode).

Ports:
- rst  in  1  synchronous reset, active-high, sampled on WrClk.
- WrClk  in  1  clock; CSR file writes on the same edge.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_op  in  3  operation code (encodings in package).
- req_csr  in  12  CSR address, CSR ops only.
- req_src  in  XLEN  rs1 value or zero-extended zimm.
- req_src_zero  in  1  rs1 index or zimm is zero.
- req_rd_zero  in  1  rd is x0.
- req_pc  in  XLEN  PC of the instruction.
- csr_rr  out  12  CSR read address.
- csr_busR  in  XLEN  CSR read data, combinational from csr_rr.
- csr_wr  out  1  CSR write enable.
- csr_rw  out  12  CSR write address.
- csr_busW  out  XLEN  CSR write data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rd_we  out  1  write rd_data to rd.
- resp_rd_data  out  XLEN  old CSR value.
- resp_redirect  out  1  take resp_pc as next PC.
- resp_pc  out  XLEN  redirect target.
- resp_illegal  out  1  req_op was an unsupported encoding.

Behaviour:
- States: IDLE, ACC, T_STAT, T_EPC, T_CAUSE, T_VEC, R_STAT, R_EPC, RESP.
- Handshake:
  - req_ready = 1 only in IDLE with rst low.
  - Accept on req_valid & req_ready; all req_* fields are latched at acceptance.
- Address rule: in every cycle with csr_wr = 1, csr_rr == csr_rw. The CSR file may decode writes from either address.
- csr_wr is 0 in IDLE, RESP, T_VEC and R_EPC. csr_rr = 0 and csr_busW = 0 in idle states.
- ACC (CSR op, one cycle):
  - csr_rr = csr_rw = latched addr.
  - Capture old = csr_busR.
  - CSRRW: write src.
  - CSRRS: write old|src; suppressed when src_zero.
  - CSRRC: write old&~src; suppressed when src_zero.
  - rd_we = !rd_zero. CSRRW with rd_zero still writes.
- ECALL sequence, one write per cycle:
  - T_STAT, addr 0x300: read-modify-write; MPIE(bit7) <= MIE(bit3), MIE <= 0, MPP(bits12:11) <= 2'b11.
  - T_EPC, 0x341: write latched pc.
  - T_CAUSE, 0x342: write ECALL_CAUSE.
  - T_VEC, 0x305: read only; capture busR & ~3 as redirect pc (direct mode).
  - rd_we = 0, redirect = 1.
- MRET sequence:
  - R_STAT, 0x300: read-modify-write; MIE <= MPIE, MPIE <= 1, MPP <= 2'b11.
  - R_EPC, 0x341: read only; capture busR as redirect pc.
  - rd_we = 0, redirect = 1.
- Illegal op: IDLE -> RESP directly, no CSR access, resp_illegal = 1, rd_we = 0, redirect = 0.
- RESP:
  - resp_valid = 1 for exactly one cycle, then IDLE.
  - resp_* fields are registered and hold their value until the next RESP.
- Latency from the acceptance edge to resp_valid: CSR op 2 cycles, ECALL 5, MRET 3, illegal 1.
- Reset:
  - State -> IDLE; resp_valid, resp_rd_we, resp_redirect, resp_illegal -> 0; resp_rd_data, resp_pc -> 0.
  - csr_wr is forced 0 in any cycle where rst = 1, including mid-sequence. No partial trap completes after reset.
  - The request is dropped, and no resp is issued for it.
- Back-to-back: the next request can be accepted the cycle after RESP. No request is accepted in a RESP cycle.

Decomposition:
- Package csr_pkg:
  - OP_CSRRW=0, OP_CSRRS=1, OP_CSRRC=2, OP_ECALL=4, OP_MRET=5; 3, 6, 7 illegal.
  - CSR addresses MSTATUS=0x300, MTVEC=0x305, MEPC=0x341, MCAUSE=0x342.
  - mstatus bit positions MIE=3, MPIE=7, MPP=12:11.
  - State enum.
- Sub-module csr_alu: combinational new-value function (op, old, src) -> wdata, we. Shared with a future pipelined CSR path.

Test Plan:
- Reset, then CSRRW 0x305, src=0x80000100, rd_zero=0 -> one write of 0x80000100 to 0x305; resp 2 cycles later with rd_data=0 (old) and rd_we=1.
- After reset, CSRRS 0x300 with src=0x8 -> write 0x1808, rd_data=0x1800. Then CSRRC 0x300 with src_zero=1 -> no csr_wr, rd_data=0x1808.
- Set mtvec=0x80000101, mstatus=0x1808, then ECALL at pc=0x80000040. Required CSR values: mstatus=0x1880, mepc=0x80000040, mcause=11. Resp 5 cycles after acceptance with redirect=1, resp_pc=0x80000100, rd_we=0.
- MRET after the above -> mstatus=0x1888, redirect to 0x80000040 after 3 cycles. Also check csr_rr==csr_rw on every write cycle.
- Assert rst during T_EPC of an ECALL -> csr_wr=0 in that cycle, mepc/mcause unchanged, no resp_valid, req_ready=1 the next cycle.
- req_op=7 -> resp_illegal=1 after 1 cycle, no csr_wr; a CSRRW presented in the RESP cycle is not accepted until IDLE.
